// File: rtl/apb2icb.sv
// APB3 completer that turns each APB transfer into one ICB command/response pair.
// A single transfer is in flight; wait states are held until the response returns or the timer expires.
module apb2icb #(
  parameter int AW          = 32,
  parameter int DW          = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            apb_psel,
  input  logic            apb_penable,
  input  logic            apb_pwrite,
  input  logic [AW-1:0]   apb_paddr,
  input  logic [DW-1:0]   apb_pwdata,
  input  logic [DW/8-1:0] apb_pstrb,
  output logic            apb_pready,
  output logic [DW-1:0]   apb_prdata,
  output logic            apb_pslverr,
  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic            o_icb_cmd_read,
  output logic [AW-1:0]   o_icb_cmd_addr,
  output logic [DW-1:0]   o_icb_cmd_wdata,
  output logic [DW/8-1:0] o_icb_cmd_wmask,
  output logic [1:0]      o_icb_cmd_size,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic            o_icb_rsp_err,
  input  logic [DW-1:0]   o_icb_rsp_rdata
);

  localparam int          MW     = DW / 8;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
  localparam bit          TO_EN  = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_RSP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic            read_q, read_d;
  logic [15:0]     timer_q, timer_d;
  logic            err_q, err_d;
  logic [DW-1:0]   prdata_q, prdata_d;
  logic            drain_q, drain_d;

  logic            to_hit_s;
  logic [15:0]     timer_inc_s;
  logic            unused_s;

  // penable carries no information here: any psel in IDLE starts a transfer
  assign unused_s    = apb_penable;
  assign to_hit_s    = TO_EN && (timer_q == TO_LIM);
  assign timer_inc_s = (timer_q == 16'hFFFF) ? timer_q : (timer_q + 16'd1);

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    read_d   = read_q;
    timer_d  = timer_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    drain_d  = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (apb_psel) begin
          addr_d   = apb_paddr;
          wdata_d  = apb_pwdata;
          read_d   = ~apb_pwrite;
          wmask_d  = apb_pwrite ? apb_pstrb : {MW{1'b1}};
          timer_d  = 16'd0;
          err_d    = 1'b0;
          drain_d  = 1'b0;
          prdata_d = {DW{1'b0}};
          state_d  = ST_CMD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CMD: begin
        // an accepted command must be followed to RSP even if the timer expires now
        if (o_icb_cmd_ready) begin
          timer_d  = 16'd0;
          state_d  = ST_RSP;
        end else if (to_hit_s) begin
          err_d    = 1'b1;
          prdata_d = {DW{1'b0}};
          state_d  = ST_DONE;
        end else begin
          timer_d  = timer_inc_s;
        end
      end
      ST_RSP: begin
        if (o_icb_rsp_valid) begin
          prdata_d = read_q ? o_icb_rsp_rdata : {DW{1'b0}};
          err_d    = o_icb_rsp_err;
          state_d  = ST_DONE;
        end else if (to_hit_s) begin
          err_d    = 1'b1;
          prdata_d = {DW{1'b0}};
          drain_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          timer_d  = timer_inc_s;
        end
      end
      ST_DONE: begin
        if (drain_q && o_icb_rsp_valid) begin
          drain_d  = 1'b0;
          state_d  = ST_IDLE;
        end else if (drain_q) begin
          state_d  = ST_DRAIN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (o_icb_rsp_valid) begin
          drain_d  = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_DRAIN;
        end
      end
      default: begin
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= {AW{1'b0}};
      wdata_q  <= {DW{1'b0}};
      wmask_q  <= {MW{1'b0}};
      read_q   <= 1'b1;
      timer_q  <= 16'd0;
      err_q    <= 1'b0;
      prdata_q <= {DW{1'b0}};
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      read_q   <= read_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      drain_q  <= drain_d;
    end
  end

  // APB results are visible only during the single DONE cycle
  assign apb_pready      = (state_q == ST_DONE);
  assign apb_pslverr     = (state_q == ST_DONE) & err_q;
  assign apb_prdata      = (state_q == ST_DONE) ? prdata_q : {DW{1'b0}};

  assign o_icb_cmd_valid = (state_q == ST_CMD);
  assign o_icb_cmd_read  = read_q;
  assign o_icb_cmd_addr  = addr_q;
  assign o_icb_cmd_wdata = wdata_q;
  assign o_icb_cmd_wmask = wmask_q;
  assign o_icb_cmd_size  = (DW == 64) ? 2'b11 : 2'b10;
  assign o_icb_rsp_ready = (state_q == ST_RSP) | (state_q == ST_DRAIN) |
                           ((state_q == ST_DONE) & drain_q);

endmodule

// File: tb/tb_apb2icb.sv
// Bench for apb2icb: directed and randomized APB transfers checked against a transaction-level model.
module tb_apb2icb;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_paddr;
  logic [63:0] apb_pwdata;
  logic [7:0]  apb_pstrb;
  logic        apb_pready, apb_pslverr;
  logic [63:0] apb_prdata;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wmask;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  always #5 clk = ~clk;

  apb2icb #(.AW(32), .DW(64), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
    .apb_pready(apb_pready), .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr),
    .o_icb_cmd_valid(cmd_valid), .o_icb_cmd_ready(cmd_ready), .o_icb_cmd_read(cmd_read),
    .o_icb_cmd_addr(cmd_addr), .o_icb_cmd_wdata(cmd_wdata), .o_icb_cmd_wmask(cmd_wmask),
    .o_icb_cmd_size(cmd_size), .o_icb_rsp_valid(rsp_valid), .o_icb_rsp_ready(rsp_ready),
    .o_icb_rsp_err(rsp_err), .o_icb_rsp_rdata(rsp_rdata)
  );

  typedef struct packed {
    int          done_at;
    int          idle_next;
    int          cmd_cycles;
    logic        err;
    logic [63:0] rdata;
  } pred_t;

  int          total = 0;
  int          bad   = 0;
  int          now   = 0;
  int          idle_at = 0;
  int          cfg_k = 0, cfg_r = 0;
  logic [63:0] cfg_rd = 64'd0;
  logic        cfg_re = 1'b0;
  int          cmd_seen = 0;
  bit          rsp_pend = 1'b0;
  int          rsp_wait = 0;
  logic [63:0] pend_rd = 64'd0;
  logic        pend_re = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level outcome: when pready appears, what it carries, when the block is free again.
  function automatic pred_t predict(int t, bit wr, int k, int r, logic [63:0] rd, logic re);
    pred_t p;
    if (k > TO) begin
      p.cmd_cycles = TO + 1;
      p.done_at    = t + TO + 2;
      p.idle_next  = p.done_at + 1;
      p.err        = 1'b1;
      p.rdata      = 64'd0;
    end else begin
      p.cmd_cycles = k + 1;
      if (r <= TO) begin
        p.done_at   = t + k + r + 3;
        p.idle_next = p.done_at + 1;
        p.err       = re;
        p.rdata     = wr ? 64'd0 : rd;
      end else begin
        p.done_at   = t + k + TO + 3;
        p.idle_next = t + k + r + 3;
        p.err       = 1'b1;
        p.rdata     = 64'd0;
      end
    end
    return p;
  endfunction

  // Advance to the next falling edge and play the ICB target for that cycle.
  task automatic tick();
    @(negedge clk);
    now++;
    if (rsp_pend && rsp_wait == 0) begin
      rsp_valid = 1'b1;
      rsp_rdata = pend_rd;
      rsp_err   = pend_re;
      if (rsp_ready) rsp_pend = 1'b0;
    end else begin
      if (rsp_pend) rsp_wait--;
      rsp_valid = 1'b0;
      rsp_rdata = {$urandom, $urandom};
      rsp_err   = ($urandom_range(0, 1) == 1);
    end
    if (cmd_valid) begin
      if (cmd_seen == cfg_k) begin
        cmd_ready = 1'b1;
        rsp_pend  = 1'b1;
        rsp_wait  = cfg_r;
        pend_rd   = cfg_rd;
        pend_re   = cfg_re;
      end else begin
        cmd_ready = 1'b0;
      end
      cmd_seen++;
    end else begin
      cmd_ready = 1'b0;
      cmd_seen  = 0;
    end
  endtask

  task automatic xfer(input string tag, input bit wr, input logic [31:0] a, input logic [63:0] wd,
                      input logic [7:0] st, input int k, input int r, input logic [63:0] rd,
                      input logic re);
    pred_t       p;
    int          t;
    int          ncmd;
    bit          seen;
    logic [42:0] exp_ctl;
    tick();
    cfg_k = k; cfg_r = r; cfg_rd = rd; cfg_re = re;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr;
    apb_paddr = a; apb_pwdata = wd; apb_pstrb = st;
    t = (now > idle_at) ? now : idle_at;
    p = predict(t, wr, k, r, rd, re);
    exp_ctl = {~wr, 2'b11, (wr ? st : 8'hFF), a};
    ncmd = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      apb_penable = 1'b1;
      if (cmd_valid) begin
        ncmd++;
        chk({tag, "/cmd_ctl"}, 128'({cmd_read, cmd_size, cmd_wmask, cmd_addr}), 128'(exp_ctl));
        chk({tag, "/cmd_wdata"}, 128'(cmd_wdata), 128'(wd));
      end
      if (apb_pready) begin
        seen = 1'b1;
        chk({tag, "/done_cycle"}, 128'(now), 128'(p.done_at));
        chk({tag, "/pslverr"}, 128'(apb_pslverr), 128'(p.err));
        chk({tag, "/prdata"}, 128'(apb_prdata), 128'(p.rdata));
      end else begin
        chk({tag, "/quiet_outs"}, 128'({apb_pslverr, apb_prdata}), 128'(0));
      end
    end
    chk({tag, "/pready_seen"}, 128'(seen), 128'(1));
    chk({tag, "/cmd_cycles"}, 128'(ncmd), 128'(p.cmd_cycles));
    idle_at = p.idle_next;
  endtask

  initial begin
    bit          wr;
    int          k, r;
    rst = 1'b1;
    apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    apb_paddr = 32'd0; apb_pwdata = 64'd0; apb_pstrb = 8'd0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = 64'd0;
    #3;
    chk("reset/ctl", 128'({cmd_valid, rsp_ready, apb_pready, apb_pslverr, cmd_read}), 128'(5'b00001));
    chk("reset/data", 128'({apb_prdata, cmd_wdata}), 128'(0));
    chk("reset/addr_mask", 128'({cmd_addr, cmd_wmask}), 128'(0));
    tick(); tick();
    rst = 1'b0;
    idle_at = now;

    xfer("t1_write", 1'b1, 32'h1000_0040, 64'h1122334455667788, 8'h0F, 0, 0, 64'h5555_AAAA_5555_AAAA, 1'b0);
    xfer("t2_read_slow", 1'b0, 32'h0000_0020, 64'h0, 8'h00, 5, 3, 64'hDEADBEEF_CAFEF00D, 1'b0);
    xfer("t3_read_err", 1'b0, 32'h0000_0100, 64'h0, 8'h00, 0, 1, 64'h0123_4567_89AB_CDEF, 1'b1);
    xfer("t4_cmd_timeout", 1'b1, 32'h0000_0200, 64'hAA, 8'hFF, 1000, 0, 64'h0, 1'b0);
    xfer("t4_after", 1'b0, 32'h0000_0208, 64'h0, 8'h00, 2, 1, 64'h0000_1111_2222_3333, 1'b0);
    xfer("t5_rsp_timeout", 1'b0, 32'h0000_0300, 64'h0, 8'h00, 0, 20, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    xfer("t5_after_drain", 1'b0, 32'h0000_0308, 64'h0, 8'h00, 1, 2, 64'h7777_8888_9999_AAAA, 1'b0);
    xfer("rsp_at_limit", 1'b0, 32'h0000_0310, 64'h0, 8'h00, 0, TO, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    xfer("rsp_in_done", 1'b1, 32'h0000_0318, 64'h1, 8'h3C, 0, TO + 1, 64'h0, 1'b0);
    xfer("after_done_drain", 1'b0, 32'h0000_0320, 64'h0, 8'h00, 0, 0, 64'hFEDC_BA98_7654_3210, 1'b0);

    // reset while the bridge waits for a response
    tick();
    cfg_k = 0; cfg_r = 100;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 32'h0000_0400;
    tick(); apb_penable = 1'b1;
    tick();
    chk("t6/in_rsp", 128'(rsp_ready), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("t6/rst_ctl", 128'({cmd_valid, rsp_ready, apb_pready, apb_pslverr, cmd_read}), 128'(5'b00001));
    chk("t6/rst_data", 128'({apb_prdata, cmd_wdata}), 128'(0));
    chk("t6/rst_addr_mask", 128'({cmd_addr, cmd_wmask}), 128'(0));
    apb_psel = 1'b0; apb_penable = 1'b0;
    rsp_pend = 1'b0; cmd_seen = 0; cmd_ready = 1'b0; rsp_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    idle_at = now;
    xfer("t6_fresh_write", 1'b1, 32'h0000_0500, 64'hCAFE, 8'h81, 0, 0, 64'h0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      wr = ($urandom_range(0, 1) == 1);
      k  = ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, TO - 1));
      r  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO + 1, TO + 12)) : int'($urandom_range(0, TO));
      xfer("rnd", wr, $urandom, {$urandom, $urandom}, 8'($urandom), k, r,
           {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        apb_psel = 1'b0; apb_penable = 1'b0;
      end
    end

    tick();
    apb_psel = 1'b0; apb_penable = 1'b0;
    chk("end/pready_single", 128'(apb_pready), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
